// File: rtl/gdt_descriptor_fetch.sv
// GDT descriptor burst sequencer: loads or stores all NUM_COLS words of one
// guest line. Ports: req_* in, rsp_* out, gdt_* drive/return the GDT port.
module gdt_descriptor_fetch #(
  parameter int LINE_W     = 3,
  parameter int COL_W      = 3,
  parameter int DATA_W     = 32,
  parameter int NUM_COLS   = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [LINE_W-1:0]          req_guest,
  input  logic                       req_store,
  input  logic [NUM_COLS*DATA_W-1:0] st_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_store,
  output logic [LINE_W-1:0]          rsp_guest,
  output logic [NUM_COLS*DATA_W-1:0] rsp_data,
  output logic                       gdt_enable,
  output logic [LINE_W-1:0]          gdt_line,
  output logic [COL_W-1:0]           gdt_column,
  output logic                       gdt_rd0_wr1,
  output logic [DATA_W-1:0]          gdt_wdata,
  input  logic [DATA_W-1:0]          gdt_rdata
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    IDLE, READ, DRAIN, WRITE, RESP
  } state_t;

  state_t state, state_nx;

  logic              ready_q;
  logic              accept;
  logic              burst;
  logic              last_col;
  logic              last_ret;
  logic [COL_W-1:0]  col_q;
  logic [LINE_W-1:0] guest_q;
  logic              store_q;
  logic [DATA_W-1:0] st_q   [NUM_COLS];
  logic [DATA_W-1:0] data_q [NUM_COLS];

  // Tag pipe follows each read until its data returns.
  logic              pipe_v [RD_LATENCY];
  logic [COL_W-1:0]  pipe_c [RD_LATENCY];

  assign burst    = (state == READ) || (state == WRITE);
  assign last_col = (col_q == LAST_COL);
  assign last_ret = pipe_v[RD_LATENCY-1] &&
                    (pipe_c[RD_LATENCY-1] == LAST_COL);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && ready_q) begin
          accept   = 1'b1;
          state_nx = req_store ? WRITE : READ;
        end
      end
      READ:  if (last_col)  state_nx = DRAIN;
      DRAIN: if (last_ret)  state_nx = RESP;
      WRITE: if (last_col)  state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q <= 1'b0;
      col_q   <= '0;
      guest_q <= '0;
      store_q <= 1'b0;
      for (int c = 0; c < NUM_COLS; c++) begin
        st_q[c]   <= '0;
        data_q[c] <= '0;
      end
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_c[i] <= '0;
      end
    end else begin
      // Holds req_ready low for the first cycle after reset.
      ready_q <= 1'b1;
      if (accept) begin
        guest_q <= req_guest;
        store_q <= req_store;
        for (int c = 0; c < NUM_COLS; c++)
          st_q[c] <= st_data[c*DATA_W +: DATA_W];
      end
      if (burst)
        col_q <= last_col ? '0 : col_q + COL_W'(1);
      pipe_v[0] <= (state == READ);
      pipe_c[0] <= col_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_c[i] <= pipe_c[i-1];
      end
      if (pipe_v[RD_LATENCY-1])
        data_q[pipe_c[RD_LATENCY-1]] <= gdt_rdata;
    end
  end

  assign req_ready   = (state == IDLE) && ready_q;
  assign rsp_valid   = (state == RESP);
  assign rsp_store   = store_q;
  assign rsp_guest   = guest_q;
  assign gdt_enable  = burst;
  assign gdt_line    = guest_q;
  assign gdt_column  = col_q;
  assign gdt_rd0_wr1 = (state == WRITE);
  assign gdt_wdata   = (state == WRITE) ? st_q[col_q] : '0;

  always_comb begin
    rsp_data = '0;
    for (int c = 0; c < NUM_COLS; c++)
      rsp_data[c*DATA_W +: DATA_W] = data_q[c];
  end

endmodule
